// File: rtl/buzzer_tone_seq_pkg.sv
// Shared state encodings, default tone table and key priority helper
// for the buzzer tone sequencer.
package buzzer_pkg;

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    BEEP = 2'd1,
    GAP  = 2'd2
  } state_t;

  localparam logic [127:0] TONE_STEPS_DEF =
    {32'd17180, 32'd12885, 32'd10308, 32'd8590};

  function automatic logic [2:0] low_idx(input logic [7:0] v);
    low_idx = 3'd0;
    for (int i = 7; i >= 0; i--) begin
      if (v[i]) low_idx = 3'(i);
    end
  endfunction

endpackage

// File: rtl/buzzer_tone_seq_nco_pwm.sv
// Phase accumulator with registered duty compare; the PWM output
// lags the accumulator by one clock.
module nco_pwm #(
  parameter int N = 32
) (
  input  logic         clk,
  input  logic         rst_n,
  input  logic         en,
  input  logic         clr,
  input  logic [N-1:0] step,
  input  logic [N-1:0] duty,
  output logic         pwm_out
);

  logic [N-1:0] acc;

  always_ff @(posedge clk or posedge rst_n) begin
    if (rst_n) begin
      acc     <= '0;
      pwm_out <= 1'b0;
    end else begin
      if (clr) begin
        acc <= '0;
      end else if (en) begin
        acc <= acc + step;
      end
      pwm_out <= (acc < duty);
    end
  end

endmodule

// File: rtl/buzzer_tone_seq.sv
// Key-triggered beep sequencer: key k plays k+1 beeps at tone k,
// with a duty cycle that advances on every accepted trigger.
module buzzer_tone_seq
  import buzzer_pkg::*;
#(
  parameter int N           = 32,
  parameter int NUM_KEYS    = 4,
  parameter logic [NUM_KEYS*N-1:0] TONE_STEPS = TONE_STEPS_DEF,
  parameter logic [N-1:0]   DUTY_STEP   = 32'd429496729,
  parameter int BEEP_CYCLES = 12_500_000,
  parameter int GAP_CYCLES  = 5_000_000
) (
  input  logic                clk,
  input  logic                rst_n,
  input  logic [NUM_KEYS-1:0] key_pulse,
  input  logic                stop,
  output logic                buzzer,
  output logic                busy,
  output logic [2:0]          beep_idx
);

  localparam int TMAX = (BEEP_CYCLES > GAP_CYCLES) ?
                        BEEP_CYCLES : GAP_CYCLES;
  localparam int TW = (TMAX < 2) ? 1 : $clog2(TMAX + 1);
  localparam logic [TW-1:0] BEEP_LAST = TW'(BEEP_CYCLES - 1);
  localparam logic [TW-1:0] GAP_LAST  = TW'(GAP_CYCLES - 1);

  state_t         state_q, state_d;
  logic [TW-1:0]  timer_q, timer_d;
  logic [3:0]     rem_q, rem_d;
  logic [N-1:0]   step_q, step_d;
  logic [N-1:0]   duty_q, duty_d;
  logic [2:0]     idx_q, idx_d;
  logic           busy_q;
  logic           pwm_out;
  logic [7:0]     keys8;
  logic [2:0]     key_sel;
  logic [N-1:0]   key_step;

  always_comb begin
    keys8 = '0;
    keys8[NUM_KEYS-1:0] = key_pulse;
  end

  assign key_sel = low_idx(keys8);

  always_comb begin
    key_step = '0;
    for (int i = 0; i < NUM_KEYS; i++) begin
      if (key_sel == 3'(i)) key_step = TONE_STEPS[i*N +: N];
    end
  end

  always_comb begin
    state_d = state_q;
    timer_d = timer_q;
    rem_d   = rem_q;
    step_d  = step_q;
    duty_d  = duty_q;
    idx_d   = idx_q;
    unique case (state_q)
      IDLE: begin
        // stop on the same edge drops the trigger entirely
        if (!stop && |key_pulse) begin
          step_d  = key_step;
          rem_d   = {1'b0, key_sel} + 4'd1;
          idx_d   = key_sel;
          duty_d  = duty_q + DUTY_STEP;
          timer_d = '0;
          state_d = BEEP;
        end
      end
      BEEP: begin
        if (stop) begin
          timer_d = '0;
          rem_d   = '0;
          state_d = IDLE;
        end else if (timer_q == BEEP_LAST) begin
          timer_d = '0;
          rem_d   = rem_q - 4'd1;
          state_d = (rem_q > 4'd1) ? GAP : IDLE;
        end else begin
          timer_d = timer_q + TW'(1);
        end
      end
      GAP: begin
        if (stop) begin
          timer_d = '0;
          rem_d   = '0;
          state_d = IDLE;
        end else if (timer_q == GAP_LAST) begin
          timer_d = '0;
          state_d = BEEP;
        end else begin
          timer_d = timer_q + TW'(1);
        end
      end
      default: begin
        timer_d = '0;
        rem_d   = '0;
        state_d = IDLE;
      end
    endcase
  end

  always_ff @(posedge clk or posedge rst_n) begin
    if (rst_n) begin
      state_q <= IDLE;
      timer_q <= '0;
      rem_q   <= '0;
      step_q  <= '0;
      duty_q  <= DUTY_STEP;
      idx_q   <= '0;
      busy_q  <= 1'b0;
    end else begin
      state_q <= state_d;
      timer_q <= timer_d;
      rem_q   <= rem_d;
      step_q  <= step_d;
      duty_q  <= duty_d;
      idx_q   <= idx_d;
      busy_q  <= (state_d != IDLE);
    end
  end

  nco_pwm #(
    .N(N)
  ) u_nco (
    .clk    (clk),
    .rst_n  (rst_n),
    .en     (state_q == BEEP),
    .clr    (state_q == IDLE),
    .step   (step_q),
    .duty   (duty_q),
    .pwm_out(pwm_out)
  );

  // state is reset asynchronously, so this silences at once on reset
  assign buzzer   = ~(pwm_out & (state_q == BEEP));
  assign busy     = busy_q;
  assign beep_idx = idx_q;

endmodule

// File: tb/tb_buzzer_tone_seq.sv
// Scoreboard bench: stimulus queues expected beep episodes, a
// negedge monitor measures each finished episode and compares.
module tb_buzzer_tone_seq;
  import buzzer_pkg::*;

  logic       clk = 1'b0;
  logic       rst_n = 1'b1;
  logic [3:0] key_pulse = '0;
  logic       stop = 1'b0;
  logic       buzzer;
  logic       busy;
  logic [2:0] beep_idx;

  int checks = 0;
  int errors = 0;

  typedef struct {
    int idx;
    int len;
    int beeps;
    int duty;
    int low;
  } exp_t;

  exp_t exp_q[$];

  buzzer_tone_seq #(
    .N          (8),
    .NUM_KEYS   (4),
    .TONE_STEPS ({8'd16, 8'd32, 8'd64, 8'd128}),
    .DUTY_STEP  (8'd64),
    .BEEP_CYCLES(20),
    .GAP_CYCLES (10)
  ) dut (
    .clk      (clk),
    .rst_n    (rst_n),
    .key_pulse(key_pulse),
    .stop     (stop),
    .buzzer   (buzzer),
    .busy     (busy),
    .beep_idx (beep_idx)
  );

  always #5 clk = ~clk;

  task automatic chk(input string nm, input int act, input int req);
    checks++;
    if (act != req) begin
      errors++;
      $display("FAIL %s: got %0d expected %0d", nm, act, req);
    end
  endtask

  task automatic pulse(input logic [3:0] k, input logic s);
    @(posedge clk);
    #1;
    key_pulse = k;
    stop = s;
    @(posedge clk);
    #1;
    key_pulse = '0;
    stop = 1'b0;
  endtask

  task automatic drain();
    int n = 0;
    while (exp_q.size() != 0 && n < 400) begin
      @(negedge clk);
      n++;
    end
    chk("drain_pending", exp_q.size(), 0);
    exp_q.delete();
    repeat (3) @(negedge clk);
  endtask

  // monitor
  initial begin
    int m_len = 0;
    int m_beeps = 0;
    int m_gaplow = 0;
    int m_low = 0;
    bit m_pbusy = 1'b0;
    bit m_pbeep = 1'b0;
    bit is_beep;
    exp_t e;
    forever begin
      @(negedge clk);
      is_beep = (dut.state_q == BEEP);
      if (rst_n) begin
        m_len = 0; m_beeps = 0; m_gaplow = 0; m_low = 0;
        m_pbusy = 1'b0; m_pbeep = 1'b0;
      end else begin
        if (busy) begin
          m_len++;
          if (is_beep && !m_pbeep) m_beeps++;
          if (!is_beep && !buzzer) m_gaplow++;
          if (!buzzer) m_low++;
        end else if (m_pbusy) begin
          if (exp_q.size() == 0) begin
            chk("unexpected_episode", 1, 0);
          end else begin
            e = exp_q.pop_front();
            chk("ep_idx", int'(beep_idx), e.idx);
            chk("ep_busy_len", m_len, e.len);
            chk("ep_beeps", m_beeps, e.beeps);
            chk("ep_duty", int'(dut.duty_q), e.duty);
            chk("ep_gap_silent", m_gaplow, 0);
            chk("ep_end_buzzer", int'(buzzer), 1);
            if (e.low >= 0) chk("ep_low_cycles", m_low, e.low);
          end
          m_len = 0; m_beeps = 0; m_gaplow = 0; m_low = 0;
        end
        m_pbusy = busy;
        m_pbeep = is_beep;
      end
    end
  end

  initial begin
    #200000;
    $display("FAIL watchdog: got timeout expected finish");
    $fatal(1, "watchdog");
  end

  initial begin
    int viol;
    int n;
    repeat (3) @(negedge clk);
    chk("rst_buzzer", int'(buzzer), 1);
    chk("rst_busy", int'(busy), 0);
    chk("rst_idx", int'(beep_idx), 0);
    chk("rst_duty", int'(dut.duty_q), 64);
    chk("rst_acc", int'(dut.u_nco.acc), 0);
    chk("rst_pwm", int'(dut.u_nco.pwm_out), 0);
    rst_n = 1'b0;

    viol = 0;
    repeat (100) begin
      @(negedge clk);
      if (buzzer !== 1'b1 || busy !== 1'b0 || beep_idx !== 3'd0)
        viol++;
    end
    chk("idle_quiet", viol, 0);

    // key 0: one beep, pwm toggles each clock
    exp_q.push_back('{0, 20, 1, 128, 11});
    pulse(4'b0001, 1'b0);
    drain();

    // key 3: four beeps, three gaps
    exp_q.push_back('{3, 110, 4, 192, -1});
    pulse(4'b1000, 1'b0);
    drain();

    // keys 1+2: key 1 wins, retrigger during beep ignored
    exp_q.push_back('{1, 50, 2, 0, -1});
    pulse(4'b0110, 1'b0);
    pulse(4'b0001, 1'b0);
    drain();

    // key 2 stopped on edge 35 (second beep)
    exp_q.push_back('{2, 35, 2, 64, -1});
    pulse(4'b0100, 1'b0);
    repeat (33) @(posedge clk);
    pulse(4'b0000, 1'b1);
    drain();

    // stop and key on the same idle edge
    pulse(4'b0001, 1'b1);
    repeat (30) @(negedge clk);
    chk("stop_key_duty", int'(dut.duty_q), 64);
    chk("stop_key_busy", int'(busy), 0);

    // trigger on the BEEP-to-IDLE edge is dropped
    exp_q.push_back('{0, 20, 1, 128, 11});
    pulse(4'b0001, 1'b0);
    repeat (18) @(posedge clk);
    pulse(4'b0001, 1'b0);
    drain();
    repeat (30) @(negedge clk);
    chk("edge_trig_busy", int'(busy), 0);
    chk("edge_trig_duty", int'(dut.duty_q), 128);

    // asynchronous reset in the middle of a beep
    pulse(4'b0001, 1'b0);
    n = 0;
    do begin
      @(negedge clk);
      n++;
    end while (buzzer !== 1'b0 && n < 10);
    chk("pre_rst_buzzer", int'(buzzer), 0);
    chk("pre_rst_duty", int'(dut.duty_q), 192);
    #2;
    rst_n = 1'b1;
    #1;
    chk("async_rst_buzzer", int'(buzzer), 1);
    chk("async_rst_busy", int'(busy), 0);
    chk("async_rst_duty", int'(dut.duty_q), 64);
    repeat (2) @(negedge clk);
    rst_n = 1'b0;

    // resume after reset
    exp_q.push_back('{1, 50, 2, 128, -1});
    pulse(4'b0010, 1'b0);
    drain();

    chk("queue_empty", exp_q.size(), 0);
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
